// File: rtl/clk_div_sched_if.sv
`default_nettype none
// ============================================================================
// clk_div_sched_if : divisor-update handshake and divider status bundle
// Rev 1.0
// ============================================================================
interface clk_div_sched_if #(
  parameter int WIDE = 32
);
  logic            iEN;
  logic            iREQ0;
  logic [WIDE-1:0] iDIV0;
  logic            oACK0;
  logic            iREQ1;
  logic [WIDE-1:0] iDIV1;
  logic            oACK1;
  logic            oERR;
  logic            oCLK_EN;
  logic            oDIV_CLK;
  logic [WIDE-1:0] oDIV_CUR;
  logic            oPEND;

  modport master (
    output iEN, iREQ0, iDIV0, iREQ1, iDIV1,
    input  oACK0, oACK1, oERR, oCLK_EN, oDIV_CLK, oDIV_CUR, oPEND
  );

  modport slave (
    input  iEN, iREQ0, iDIV0, iREQ1, iDIV1,
    output oACK0, oACK1, oERR, oCLK_EN, oDIV_CLK, oDIV_CUR, oPEND
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// clk_div_sched : round-robin scheduled programmable clock-enable divider
// Rev 1.0
// ============================================================================
module clk_div_sched #(
  parameter int WIDE    = 32,
  parameter int DEF_DIV = 2
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  clk_div_sched_if.slave bus
);
  localparam logic [WIDE-1:0] C_DEF_DIV = WIDE'(DEF_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t          r_state, w_state_nx;
  logic [WIDE-1:0] r_cnt, w_cnt_nx;
  logic [WIDE-1:0] r_div_cur, w_div_cur_nx;
  logic [WIDE-1:0] r_div_new, w_div_new_nx;
  logic            r_ptr;
  logic            r_ack0_d, r_ack1_d;
  logic            r_div_clk;

  logic            w_run, w_last;
  logic [WIDE:0]   w_half;
  logic            w_elig0, w_elig1, w_gnt0, w_gnt1, w_gnt, w_zero, w_take;
  logic [WIDE-1:0] w_gdiv, w_cnt_inc;

  assign w_run     = (r_state != S_IDLE);
  assign w_last    = (r_cnt == r_div_cur - 1'b1);
  assign w_half    = ({1'b0, r_div_cur} + {{WIDE{1'b0}}, 1'b1}) >> 1;
  assign w_cnt_inc = w_last ? '0 : r_cnt + 1'b1;

  // Grants are gated by reset so no ACK escapes while reset is asserted.
  assign w_elig0 = iRST_N && bus.iREQ0 && !r_ack0_d && (r_state != S_PEND);
  assign w_elig1 = iRST_N && bus.iREQ1 && !r_ack1_d && (r_state != S_PEND);
  assign w_gnt0  = w_elig0 && (!w_elig1 || !r_ptr);
  assign w_gnt1  = w_elig1 && (!w_elig0 ||  r_ptr);
  assign w_gnt   = w_gnt0 || w_gnt1;
  assign w_gdiv  = w_gnt1 ? bus.iDIV1 : bus.iDIV0;
  assign w_zero  = (w_gdiv == '0);
  assign w_take  = w_gnt && !w_zero;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_div_cur_nx = r_div_cur;
    w_div_new_nx = r_div_new;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (w_take) w_div_cur_nx = w_gdiv;
        if (bus.iEN) w_state_nx = S_RUN;
      end
      S_RUN: begin
        if (!bus.iEN) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          if (w_take) w_div_cur_nx = w_gdiv;
        end else begin
          w_cnt_nx = w_cnt_inc;
          if (w_take) begin
            w_div_new_nx = w_gdiv;
            w_state_nx   = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (!bus.iEN) begin
          w_div_cur_nx = r_div_new;
          w_cnt_nx     = '0;
          w_state_nx   = S_IDLE;
        end else if (w_last) begin
          w_div_cur_nx = r_div_new;
          w_cnt_nx     = '0;
          w_state_nx   = S_RUN;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div_cur <= C_DEF_DIV;
      r_div_new <= C_DEF_DIV;
      r_ptr     <= 1'b0;
      r_ack0_d  <= 1'b0;
      r_ack1_d  <= 1'b0;
      r_div_clk <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_div_cur <= w_div_cur_nx;
      r_div_new <= w_div_new_nx;
      r_ack0_d  <= w_gnt0;
      r_ack1_d  <= w_gnt1;
      if (w_elig0 && w_elig1) r_ptr <= w_gnt0;
      // Dropping iEN forces the level low as the divider enters IDLE.
      r_div_clk <= w_run && bus.iEN && ({1'b0, r_cnt} < w_half);
    end
  end

  assign bus.oACK0    = w_gnt0;
  assign bus.oACK1    = w_gnt1;
  assign bus.oERR     = w_gnt && w_zero;
  assign bus.oCLK_EN  = w_run && w_last;
  assign bus.oDIV_CLK = r_div_clk;
  assign bus.oDIV_CUR = r_div_cur;
  assign bus.oPEND    = (r_state == S_PEND);
endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ============================================================================
// tb_clk_div_sched : directed self-checking bench for clk_div_sched (WIDE=8)
// Rev 1.0
// ============================================================================
module tb_clk_div_sched;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  clk_div_sched_if #(.WIDE(8)) bus ();

  clk_div_sched #(.WIDE(8), .DEF_DIV(2)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.iEN   = 1'b0;
    bus.iREQ0 = 1'b1;
    bus.iDIV0 = 8'd7;
    bus.iREQ1 = 1'b0;
    bus.iDIV1 = 8'd0;

    // reset state
    nxt();
    chk("rst_div_cur", bus.oDIV_CUR, 2);
    chk("rst_clk_en", bus.oCLK_EN, 0);
    chk("rst_div_clk", bus.oDIV_CLK, 0);
    chk("rst_pend", bus.oPEND, 0);
    chk("rst_ack0", bus.oACK0, 0);
    chk("rst_err", bus.oERR, 0);
    bus.iREQ0 = 1'b0;
    rst_n     = 1'b1;

    // default divisor 2
    nxt();
    bus.iEN = 1'b1;
    chk("idle_clk_en", bus.oCLK_EN, 0);
    nxt(); chk("d2_en_c1", bus.oCLK_EN, 0); chk("d2_clk_c1", bus.oDIV_CLK, 0);
    nxt(); chk("d2_en_c2", bus.oCLK_EN, 1); chk("d2_clk_c2", bus.oDIV_CLK, 1);
    nxt(); chk("d2_en_c3", bus.oCLK_EN, 0); chk("d2_clk_c3", bus.oDIV_CLK, 0);
    nxt(); chk("d2_en_c4", bus.oCLK_EN, 1); chk("d2_clk_c4", bus.oDIV_CLK, 1);
    nxt(); bus.iEN = 1'b0;

    // grant in IDLE applies 5 at once
    nxt();
    bus.iREQ0 = 1'b1; bus.iDIV0 = 8'd5; #1;
    chk("idle_ack0", bus.oACK0, 1);
    chk("idle_err", bus.oERR, 0);
    chk("idle_div_clk", bus.oDIV_CLK, 0);
    nxt();
    bus.iREQ0 = 1'b0;
    chk("idle_div5", bus.oDIV_CUR, 5);
    chk("idle_nopend", bus.oPEND, 0);
    bus.iEN = 1'b1;
    nxt();
    // change 5 -> 3 requested at cnt=1
    nxt();
    bus.iREQ0 = 1'b1; bus.iDIV0 = 8'd3; #1;
    chk("run_ack0", bus.oACK0, 1);
    chk("run_pend_before", bus.oPEND, 0);
    nxt(); bus.iREQ0 = 1'b0; chk("pend_set", bus.oPEND, 1);
    nxt();
    nxt();
    chk("pend_last", bus.oPEND, 1);
    chk("pend_last_en", bus.oCLK_EN, 1);
    chk("pend_old_div", bus.oDIV_CUR, 5);
    nxt();
    chk("d3_applied", bus.oDIV_CUR, 3);
    chk("d3_pend_clr", bus.oPEND, 0);
    chk("d3_en_cnt0", bus.oCLK_EN, 0);
    nxt(); chk("d3_clk_a", bus.oDIV_CLK, 1);
    nxt(); chk("d3_clk_b", bus.oDIV_CLK, 1); chk("d3_en", bus.oCLK_EN, 1);
    nxt(); chk("d3_clk_c", bus.oDIV_CLK, 0); chk("d3_en_off", bus.oCLK_EN, 0);

    // zero divisor rejected; held request blocked one cycle
    nxt();
    bus.iREQ1 = 1'b1; bus.iDIV1 = 8'd0; #1;
    chk("zero_ack1", bus.oACK1, 1);
    chk("zero_err", bus.oERR, 1);
    nxt();
    chk("zero_block", bus.oACK1, 0);
    chk("zero_cadence", bus.oCLK_EN, 1);
    chk("zero_div_keep", bus.oDIV_CUR, 3);
    chk("zero_nopend", bus.oPEND, 0);
    nxt();
    chk("zero_rearb_ack", bus.oACK1, 1);
    chk("zero_rearb_err", bus.oERR, 1);
    bus.iREQ1 = 1'b0;

    // divisor 1
    nxt();
    bus.iREQ0 = 1'b1; bus.iDIV0 = 8'd1; #1;
    chk("d1_ack0", bus.oACK0, 1);
    nxt(); bus.iREQ0 = 1'b0; chk("d1_pend_en", bus.oCLK_EN, 1); chk("d1_pend", bus.oPEND, 1);
    nxt(); chk("d1_div", bus.oDIV_CUR, 1); chk("d1_en0", bus.oCLK_EN, 1);
    nxt(); chk("d1_en1", bus.oCLK_EN, 1); chk("d1_clk1", bus.oDIV_CLK, 1);
    nxt(); chk("d1_en2", bus.oCLK_EN, 1); chk("d1_clk2", bus.oDIV_CLK, 1);

    // divisor 255 at WIDE=8
    bus.iREQ1 = 1'b1; bus.iDIV1 = 8'd255; #1;
    chk("d255_ack1", bus.oACK1, 1);
    nxt(); bus.iREQ1 = 1'b0; chk("d255_pend", bus.oPEND, 1);
    nxt(); chk("d255_div", bus.oDIV_CUR, 255); chk("d255_nopend", bus.oPEND, 0);
    repeat (128) nxt();
    chk("d255_clk_hi", bus.oDIV_CLK, 1);
    nxt(); chk("d255_clk_lo", bus.oDIV_CLK, 0);
    repeat (125) nxt();
    chk("d255_wrap_en", bus.oCLK_EN, 1);
    nxt(); chk("d255_cnt0_en", bus.oCLK_EN, 0);
    nxt(); chk("d255_clk_restart", bus.oDIV_CLK, 1);

    // iEN dropped while pending: divisor loaded on entry to IDLE
    bus.iREQ0 = 1'b1; bus.iDIV0 = 8'd4; #1;
    chk("pen_ack0", bus.oACK0, 1);
    nxt(); bus.iREQ0 = 1'b0; chk("pen_pend", bus.oPEND, 1); bus.iEN = 1'b0;
    nxt();
    chk("pen_div4", bus.oDIV_CUR, 4);
    chk("pen_idle_nopend", bus.oPEND, 0);
    chk("pen_idle_clk", bus.oDIV_CLK, 0);
    chk("pen_idle_en", bus.oCLK_EN, 0);
    bus.iEN = 1'b1;
    nxt();
    nxt();
    nxt(); chk("d4_clk", bus.oDIV_CLK, 1);
    bus.iREQ1 = 1'b1; bus.iDIV1 = 8'd9; #1;
    chk("d9_ack1", bus.oACK1, 1);
    nxt();
    bus.iREQ1 = 1'b0; bus.iREQ0 = 1'b1; bus.iDIV0 = 8'd7;
    chk("d9_pend", bus.oPEND, 1);
    chk("d4_en", bus.oCLK_EN, 1);

    // asynchronous reset mid-operation discards the pending divisor
    rst_n = 1'b0; #1;
    chk("arst_div", bus.oDIV_CUR, 2);
    chk("arst_en", bus.oCLK_EN, 0);
    chk("arst_clk", bus.oDIV_CLK, 0);
    chk("arst_pend", bus.oPEND, 0);
    chk("arst_ack0", bus.oACK0, 0);
    bus.iREQ0 = 1'b0;
    nxt();
    rst_n = 1'b1; bus.iEN = 1'b1;

    // simultaneous requests: RR starts at requester 0
    nxt();
    chk("rr_div2", bus.oDIV_CUR, 2);
    bus.iREQ0 = 1'b1; bus.iDIV0 = 8'd4;
    bus.iREQ1 = 1'b1; bus.iDIV1 = 8'd6; #1;
    chk("rr_ack0", bus.oACK0, 1);
    chk("rr_no_ack1", bus.oACK1, 0);
    nxt(); bus.iREQ0 = 1'b0; #1;
    chk("rr_pend_noack", bus.oACK1, 0);
    chk("rr_pend", bus.oPEND, 1);
    nxt();
    chk("rr_div4", bus.oDIV_CUR, 4);
    chk("rr_ack1", bus.oACK1, 1);
    nxt(); bus.iREQ1 = 1'b0; chk("rr_pend2", bus.oPEND, 1);
    nxt();
    nxt(); chk("rr_d4_en", bus.oCLK_EN, 1); chk("rr_d4_pend", bus.oPEND, 1);
    nxt(); chk("rr_div6", bus.oDIV_CUR, 6); chk("rr_nopend", bus.oPEND, 0);
    repeat (4) nxt();
    chk("rr_d6_en_off", bus.oCLK_EN, 0);
    nxt(); chk("rr_d6_en", bus.oCLK_EN, 1);

    // second contention goes to requester 1
    nxt();
    bus.iREQ0 = 1'b1; bus.iDIV0 = 8'd2;
    bus.iREQ1 = 1'b1; bus.iDIV1 = 8'd3; #1;
    chk("rr2_ack1", bus.oACK1, 1);
    chk("rr2_no_ack0", bus.oACK0, 0);
    nxt(); bus.iREQ1 = 1'b0; #1;
    chk("rr2_pend_noack0", bus.oACK0, 0);
    chk("rr2_pend", bus.oPEND, 1);
    bus.iREQ0 = 1'b0;
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
